heichips25_systolic_host: RTL
=============================

// Module: heichips25_systolic_host
// PURPOSE
//  Host-side sequencer for the 4x4 systolic-array pin protocol. It buffers weight and input
//  matrices written by a local host, and serialises them onto the array's data/load pins.
//  It then requests outputs and captures the returned result stream into a readback buffer.
//  It sits in the test harness / companion logic, wired pin-for-pin to the array top.
// PARAMETERS
//  BITWIDTH  4   operand width per element on arr_data
//  OUTWIDTH  8   result width per element on arr_results
//  N         4   array dimension; each matrix holds N*N elements, sent row-major
//  TIMEOUT   64  max cycles in COLLECT without arr_valid before aborting
// PORTS
//  clk                 in   1         clock
//  rst_n               in   1         async reset, active low
//  cfg_we              in   1         write one element into the staging buffers
//  cfg_addr            in   6         [5:4]=0 weights, 1 inputs (2/3 ignored); [3:0] element index
//  cfg_wdata           in   BITWIDTH  element value
//  start               in   1         begin a transfer (sampled only in IDLE)
//  busy                out  1         high in every state except IDLE
//  done                out  1         one-cycle pulse when a transfer ends (ok or error)
//  error               out  1         sticky timeout flag; cleared by next accepted start
//  rd_addr             in   4         result buffer index
//  rd_data             out  OUTWIDTH  result_buf[rd_addr], combinational read
//  arr_data            out  BITWIDTH  element driven to array
//  arr_load_weights    out  1         weight-load strobe
//  arr_load_inputs     out  1         input-load strobe
//  arr_store_outputs   out  1         output-request pulse
//  arr_results         in   OUTWIDTH  result element from array
//  arr_valid           in   1         arr_results valid this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all arr_* outputs 0; busy=done=error=0; counters 0.
//  Staging and result buffers are not reset; rd_data is undefined until the first done.
//  cfg_we is accepted only in IDLE and ignored while busy; there is no back-pressure.
//  FSM states: IDLE, LOAD_W, LOAD_I, STORE, COLLECT, FIN.
//   IDLE    : start=1 -> LOAD_W, idx=0, error cleared.
//   LOAD_W  : arr_load_weights=1, arr_data=wbuf[idx] for N*N consecutive cycles.
//             idx increments each cycle; at idx=N*N-1 -> LOAD_I with idx=0.
//   LOAD_I  : same as LOAD_W using ibuf and arr_load_inputs; after the last element -> STORE.
//   STORE   : arr_store_outputs=1 for exactly one cycle, arr_data=0 -> COLLECT, ridx=0, tmo=0.
//   COLLECT : each cycle with arr_valid=1 writes result_buf[ridx]=arr_results and
//             increments ridx; tmo resets to 0.
//             ridx reaches N*N (the 16th capture) -> FIN.
//             Otherwise tmo increments; tmo==TIMEOUT-1 with no valid -> error=1, FIN.
//   FIN     : done=1 for one cycle -> IDLE.
//  Strobe rules: load strobes are never high together; strobes are registered outputs.
//   The first weight appears 1 cycle after start is sampled.
//  Latency: store strobe lands at cycle 2*N*N+1 after start (33 for N=4).
//  arr_valid outside COLLECT is ignored. Valid beats beyond N*N are dropped (already in FIN).
//  start while busy is ignored. Reset mid-transfer drops all strobes to 0 asynchronously and
//   returns to IDLE; a partial result_buf is kept but not flagged done.
//  Widths: idx/ridx are clog2(N*N)+1 bits; tmo is clog2(TIMEOUT) bits.
// TESTING
//  1. Write wbuf[i]=i, ibuf[i]=15-i, start -> arr_load_weights high 16 cycles with data 0..15,
//     then arr_load_inputs high 16 cycles with data 15..0, then a 1-cycle store at start+33.
//  2. Array model returns 16 valid beats of value 8'h10+k -> rd_data[k]=8'h10+k, done pulses once,
//     error=0.
//  3. Valid beats with gaps (valid every 3rd cycle) -> all 16 values captured in order, no error.
//  4. No arr_valid after store -> done and error assert at COLLECT cycle 64; next start clears error.
//  5. Pulse rst_n low during LOAD_I element 7 -> all strobes 0 immediately, busy=0, no done pulse.
//  6. Assert start and cfg_we mid-transfer -> no restart, buffers unchanged, sequence completes
//     normally.

Source files
------------

// File: rtl/heichips25_systolic_host.sv
// Host sequencer for the 4x4 systolic array: streams weights, inputs, store request, collects results.
// Latency: first weight 1 cycle after start, store strobe 2*N*N+1 cycles after start.
// No back-pressure: cfg writes and start are ignored while busy; COLLECT aborts after TIMEOUT idle cycles.
module heichips25_systolic_host #(
  parameter int BITWIDTH = 4,
  parameter int OUTWIDTH = 8,
  parameter int N        = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [BITWIDTH-1:0] cfg_wdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic [3:0]          rd_addr,
  output logic [OUTWIDTH-1:0] rd_data,
  output logic [BITWIDTH-1:0] arr_data,
  output logic                arr_load_weights,
  output logic                arr_load_inputs,
  output logic                arr_store_outputs,
  input  logic [OUTWIDTH-1:0] arr_results,
  input  logic                arr_valid
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN) + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, STORE, COLLECT, FIN} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [IW-1:0]       ridx, ridx_nxt;
  logic [TW-1:0]       tmo, tmo_nxt;
  logic                err_nxt;
  logic                cap;
  logic [BITWIDTH-1:0] data_nxt;

  logic [BITWIDTH-1:0] wbuf [NN];
  logic [BITWIDTH-1:0] ibuf [NN];
  logic [OUTWIDTH-1:0] result_buf [NN];

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign rd_data = result_buf[rd_addr];

  // Staging buffers: host writes land only while idle so a transfer sees a stable snapshot.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      if (cfg_addr[5:4] == 2'd0) wbuf[cfg_addr[3:0]] <= cfg_wdata;
      if (cfg_addr[5:4] == 2'd1) ibuf[cfg_addr[3:0]] <= cfg_wdata;
    end
  end

  // Result capture; deliberately unreset so a partial result survives a mid-transfer reset.
  always_ff @(posedge clk) begin
    if (cap) result_buf[ridx[IW-2:0]] <= arr_results;
  end

  // Next-state, counters and the value the registered pin outputs take next cycle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ridx_nxt  = ridx;
    tmo_nxt   = tmo;
    err_nxt   = error;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_W;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      LOAD_W: begin
        if (idx == IW'(NN - 1)) begin
          state_nxt = LOAD_I;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      LOAD_I: begin
        if (idx == IW'(NN - 1)) begin
          state_nxt = STORE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      STORE: begin
        state_nxt = COLLECT;
        ridx_nxt  = '0;
        tmo_nxt   = '0;
      end
      COLLECT: begin
        if (arr_valid) begin
          cap      = 1'b1;
          ridx_nxt = ridx + 1'b1;
          tmo_nxt  = '0;
          if (ridx == IW'(NN - 1)) state_nxt = FIN;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = FIN;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    data_nxt = '0;
    if (state_nxt == LOAD_W) data_nxt = wbuf[idx_nxt[IW-2:0]];
    if (state_nxt == LOAD_I) data_nxt = ibuf[idx_nxt[IW-2:0]];
  end

  // State, counters and registered pin outputs; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      idx               <= '0;
      ridx              <= '0;
      tmo               <= '0;
      error             <= 1'b0;
      arr_data          <= '0;
      arr_load_weights  <= 1'b0;
      arr_load_inputs   <= 1'b0;
      arr_store_outputs <= 1'b0;
    end else begin
      state             <= state_nxt;
      idx               <= idx_nxt;
      ridx              <= ridx_nxt;
      tmo               <= tmo_nxt;
      error             <= err_nxt;
      arr_data          <= data_nxt;
      arr_load_weights  <= (state_nxt == LOAD_W);
      arr_load_inputs   <= (state_nxt == LOAD_I);
      arr_store_outputs <= (state_nxt == STORE);
    end
  end

endmodule
